silly_function: RTL and testbench
=================================

# silly_function

Three-input Boolean function block: y = (~b & ~c) | (a & ~b), i.e. true for {a,b,c} = 000, 100, 101. It is evaluated bitwise over WIDTH independent lanes. The block provides a combinational result plus a one-cycle registered copy, and can optionally include a saturating statistics counter. It is a leaf block used wherever the reference logic function is needed.

## Interface
- WIDTH, default 1: number of independent lanes.
- CNT_W, default 16: width of the statistics counter.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand a per lane.
- b  input  WIDTH  operand b per lane.
- c  input  WIDTH  operand c per lane.
- y  output  WIDTH  combinational result per lane.
- y_q  output  WIDTH  y registered on clk.
- hit_cnt  output  CNT_W  cycles in which y_q[0] was 1; present only with stats enabled.

## Operation
- Per lane i: y[i] = (~b[i] & ~c[i]) | (a[i] & ~b[i]).
- Full truth table for {a,b,c}:
  - 000→1, 001→0, 010→0, 011→0
  - 100→1, 101→1, 110→0, 111→0
- y is purely combinational. It involves no clock and settles within the same delta as the input change.
- X/Z on any input of a lane may propagate to that lane only; lanes are fully independent.
- y_q: at each rising clk edge, y_q ← reset ? 0 : y.
- hit_cnt:
  - At each rising clk edge, hit_cnt ← reset ? 0 : hit_cnt + y_q[0].
  - Saturates at all-ones; it never wraps.

## Timing
- y: zero-cycle latency, combinational path from a/b/c.
- y_q: one-cycle latency. The value sampled at edge n appears after edge n.
- hit_cnt: counts y_q[0] as of the current edge, so an input change reaches the count two edges later.
- Reset values: y_q = 0, hit_cnt = 0. y is unaffected by reset.
- Reset asserted mid-stream clears y_q and hit_cnt at the next edge; y keeps tracking the inputs.
- When hit_cnt is at saturation with y_q[0] = 1, it holds all-ones.
- When reset and saturation occur together, reset wins.

## Configuration
- SILLY_FUNCTION_STATS_EN defined:
  - The hit_cnt port is present.
  - The counter is instantiated.
- SILLY_FUNCTION_STATS_EN undefined:
  - The hit_cnt port and counter logic are absent.
  - y and y_q behave identically to the enabled build.

## Structure
- Package silly_function_pkg:
  - TRUTH_TABLE = 8'b0011_0001, indexed by {a,b,c}.
  - Default WIDTH and CNT_W constants.
- One sub-module, silly_function_lane: a single-bit combinational evaluator (a, b, c → y), instantiated WIDTH times by generate.
- Registered output and counter live in the top module.

## Test plan
- WIDTH=1, sweep {a,b,c} 000..111 with 10 time-unit steps, no clock required → y = 1,0,0,0,1,1,0,0 respectively.
- WIDTH=4, a=4'b1010, b=4'b0000, c=4'b1100 → y = 4'b1011.
- Hold reset high 2 cycles, then release with a=1,b=0,c=1 → y_q = 0 during reset; y_q = 1 one edge after release; y = 1 throughout.
- Stats build, CNT_W=4, hold a=1,b=0,c=0 for 20 cycles after reset → hit_cnt climbs to 4'hF and holds at 4'hF.
- Stats build, hit_cnt = 5, then assert reset for one cycle → hit_cnt = 0 and y_q = 0 on the next edge.
- Build without SILLY_FUNCTION_STATS_EN → compiles with no hit_cnt port; y and y_q match the stats build for the first scenario's sweep.

Source files
------------

// File: rtl/silly_function_pkg.sv
// silly_function_pkg: shared constants for the silly_function block.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// TRUTH_TABLE is indexed by {a,b,c}; bit k is the result for input code k.
// Codes 000, 100 and 101 evaluate to 1.
package silly_function_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  localparam logic [7:0] TRUTH_TABLE = 8'b0011_0001;

endpackage

// File: rtl/silly_function_lane.sv
// silly_function_lane: single-bit evaluator, y = (~b & ~c) | (a & ~b).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the output always reflects the current inputs.
//
// Ports:
//   a, b, c : operand bits of one lane
//   y       : function result for that lane
module silly_function_lane
  import silly_function_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  // The table lookup is the reference form of the function.
  assign y = TRUTH_TABLE[{a, b, c}];

endmodule

// File: rtl/silly_function.sv
// silly_function: WIDTH-lane Boolean function with a registered copy and an
// optional saturating hit counter (enabled by SILLY_FUNCTION_STATS_EN).
// Latency: y is combinational; y_q is one cycle; hit_cnt lags inputs by two edges.
// Backpressure: none; every cycle is evaluated unconditionally.
//
// Ports:
//   clk     : sole clock, rising edge
//   reset   : synchronous, active-high; clears y_q and hit_cnt, not y
//   a, b, c : per-lane operands
//   y       : per-lane combinational result
//   y_q     : y registered on clk
//   hit_cnt : cycles in which y_q[0] was 1, saturating (stats build only)
module silly_function
  import silly_function_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
`ifdef SILLY_FUNCTION_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("silly_function: WIDTH and CNT_W must both be at least 1");
  end

  // Lanes are fully independent, so an unknown on one lane stays there.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    silly_function_lane u_lane (
      .a (a[i]),
      .b (b[i]),
      .c (c[i]),
      .y (y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

`ifdef SILLY_FUNCTION_STATS_EN
  // Counts the registered lane 0 result, so it trails y_q by one edge.
  // Holds at all-ones instead of wrapping; reset takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt <= '0;
    end else if (y_q[0] && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_silly_function.sv
// tb_silly_function: directed bench for silly_function.
// Instance dut is WIDTH=1, CNT_W=4; instance dut4 is WIDTH=4, default CNT_W.
// Counter checks are active when SILLY_FUNCTION_STATS_EN is defined.
module tb_silly_function;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] a = '0;
  logic [0:0] b = '0;
  logic [0:0] c = '0;
  wire  [0:0] y;
  wire  [0:0] y_q;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] c4 = '0;
  wire  [3:0] y4;
  wire  [3:0] y_q4;
`ifdef SILLY_FUNCTION_STATS_EN
  wire  [3:0]  hit_cnt;
  wire  [15:0] hit_cnt4;
`endif

  int checks = 0;
  int failures = 0;

  // Expected-state model
  logic       exp_yq = 1'b0;
  logic [3:0] exp_yq4 = 4'h0;
  logic [3:0] exp_cnt = 4'h0;

  always #5 clk = ~clk;

  silly_function #(.WIDTH(1), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .c       (c),
    .y       (y),
    .y_q     (y_q)
`ifdef SILLY_FUNCTION_STATS_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  silly_function #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .a       (a4),
    .b       (b4),
    .c       (c4),
    .y       (y4),
    .y_q     (y_q4)
`ifdef SILLY_FUNCTION_STATS_EN
    ,
    .hit_cnt (hit_cnt4)
`endif
  );

  function automatic logic ref_y(input logic fa, input logic fb, input logic fc);
    return (~fb & ~fc) | (fa & ~fb);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, updating the model with the inputs seen at the edge.
  task automatic tick();
    logic       nxt_yq;
    logic [3:0] nxt_yq4;
    logic [3:0] nxt_cnt;
    nxt_yq = reset ? 1'b0 : ref_y(a[0], b[0], c[0]);
    for (int i = 0; i < 4; i++) begin
      nxt_yq4[i] = reset ? 1'b0 : ref_y(a4[i], b4[i], c4[i]);
    end
    if (reset) nxt_cnt = 4'h0;
    else if (exp_cnt == 4'hF) nxt_cnt = 4'hF;
    else nxt_cnt = exp_cnt + {3'b000, exp_yq};
    @(posedge clk);
    #1;
    exp_yq  = nxt_yq;
    exp_yq4 = nxt_yq4;
    exp_cnt = nxt_cnt;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_y_q"}, {31'd0, y_q}, {31'd0, exp_yq});
    check({tag, "_y_q4"}, {28'd0, y_q4}, {28'd0, exp_yq4});
`ifdef SILLY_FUNCTION_STATS_EN
    check({tag, "_hit_cnt"}, {28'd0, hit_cnt}, {28'd0, exp_cnt});
`endif
  endtask

  initial begin
    int         sweep_exp [8];
    logic [2:0] code;
    logic [2:0] toggles [4];
    sweep_exp = '{1, 0, 0, 0, 1, 1, 0, 0};
    toggles   = '{3'b010, 3'b000, 3'b111, 3'b101};

    // Combinational sweep over all input codes, 10 time units per step
    for (int i = 0; i < 8; i++) begin
      code = i[2:0];
      a = code[2];
      b = code[1];
      c = code[0];
      #1;
      check($sformatf("sweep_%0d", i), {31'd0, y}, sweep_exp[i]);
      #9;
    end

    // Reset state
    tick();
    check_state("reset_state");
    check("reset_y_q_zero", {31'd0, y_q}, 32'd0);

    // Independent lanes
    a4 = 4'b1010; b4 = 4'b0000; c4 = 4'b1100;
    #1;
    check("lanes_y4", {28'd0, y4}, 32'h0000_000B);

    // Reset held two cycles, then released with a=1,b=0,c=1
    reset = 1'b1;
    a = 1'b1; b = 1'b0; c = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_hold_%0d_y_q", i), {31'd0, y_q}, 32'd0);
      check($sformatf("rst_hold_%0d_y", i), {31'd0, y}, 32'd1);
    end
    reset = 1'b0;
    #1;
    check("rst_release_pre_y_q", {31'd0, y_q}, 32'd0);
    tick();
    check("rst_release_y_q", {31'd0, y_q}, 32'd1);
    check("rst_release_y", {31'd0, y}, 32'd1);
    check_state("rst_release");

    // Registered path follows changing inputs with one cycle of latency
    a4 = 4'b0110; b4 = 4'b0011; c4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      code = toggles[i];
      a = code[2];
      b = code[1];
      c = code[0];
      tick();
      check_state($sformatf("toggle_%0d", i));
    end

    // Count up to 5 hits, then a one-cycle mid-stream reset
    a = 1'b1; b = 1'b0; c = 1'b0;
    for (int i = 0; i < 20 && exp_cnt != 4'd5; i++) begin
      tick();
      check_state($sformatf("climb5_%0d", i));
    end
`ifdef SILLY_FUNCTION_STATS_EN
    check("cnt_at_5", {28'd0, hit_cnt}, 32'd5);
`endif
    reset = 1'b1;
    tick();
    check_state("midrst");
    check("midrst_y_q", {31'd0, y_q}, 32'd0);
    check("midrst_y", {31'd0, y}, 32'd1);
`ifdef SILLY_FUNCTION_STATS_EN
    check("midrst_hit_cnt", {28'd0, hit_cnt}, 32'd0);
`endif
    reset = 1'b0;

    // Hold a=1,b=0,c=0 for 20 cycles: counter saturates and holds
    for (int i = 0; i < 20; i++) begin
      tick();
      check_state($sformatf("sat_%0d", i));
    end
`ifdef SILLY_FUNCTION_STATS_EN
    check("sat_final", {28'd0, hit_cnt}, 32'h0000_000F);
`endif
    check("sat_final_y_q", {31'd0, y_q}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
